pc_loop_watchdog: RTL

Synthesizable execution monitor for the rv32i core: watches the PC on every instruction fetch and flags a hang or a spin loop. It detects repeating PC patterns of any period from 1 to MAX_PERIOD and enforces a cycle budget. Its `halt_req` lets the system freeze the core, and the bench ends simulation on it. It sits beside the core in `rv32i_system`, fed from the FETCH-state strobe and the PC register output.

---
 rtl/pc_loop_watchdog.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_loop_watchdog.sv
// pc_loop_watchdog: flags PC spin loops of period 1..MAX_PERIOD and a MONITOR cycle budget.
module pc_loop_watchdog #(
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 10,
  parameter int MAX_PERIOD = 4,
  parameter int MAX_CYCLES = 100
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              clear,
  input  logic                              fetch_valid,
  input  logic [PC_WIDTH-1:0]               pc,
  output logic                              loop_detected,
  output logic [$clog2(MAX_PERIOD+1)-1:0]   loop_period,
  output logic [PC_WIDTH-1:0]               loop_pc,
  output logic                              timeout,
  output logic                              halt_req,
  output logic [31:0]                       fetch_count
);
  localparam int PW = $clog2(MAX_PERIOD+1);
  localparam int RW = $clog2((DEPTH-1)*MAX_PERIOD+1);
  localparam int CW = MAX_CYCLES > 0 ? $clog2(MAX_CYCLES+1) : 1;
  typedef enum logic [1:0] {IDLE, MONITOR, LOOP, TIMEOUT} state_t;
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] hist_q [1:MAX_PERIOD];
  logic [PC_WIDTH-1:0] hist_d [1:MAX_PERIOD];
  logic [RW-1:0]       run_q  [1:MAX_PERIOD];
  logic [RW-1:0]       run_d  [1:MAX_PERIOD];
  logic [RW-1:0]       run_n  [1:MAX_PERIOD];
  logic [PW-1:0]       vdepth_q, vdepth_d, per_q, per_d, hit_p;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [31:0]         fcnt_q, fcnt_d;
  logic [PC_WIDTH-1:0] lpc_q, lpc_d;
  logic                det_q, det_d, to_q, to_d, hit, wipe;
  // Dropping enable while monitoring wipes progress exactly like clear.
  assign wipe = clear | (state_q == MONITOR & ~enable);
  always_comb begin
    hit = 1'b0;
    hit_p = '0;
    for (int p = MAX_PERIOD; p >= 1; p--) begin
      run_n[p] = (vdepth_q >= PW'(p) && pc == hist_q[p]) ? (run_q[p] == '1 ? run_q[p] : run_q[p] + RW'(1)) : '0;
      if (run_n[p] == RW'((DEPTH-1)*p)) begin
        hit = 1'b1;
        hit_p = PW'(p);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    hist_d = hist_q;
    run_d = run_q;
    vdepth_d = vdepth_q;
    cyc_d = cyc_q;
    fcnt_d = fcnt_q;
    det_d = det_q;
    per_d = per_q;
    lpc_d = lpc_q;
    to_d = to_q;
    if (state_q == IDLE && enable) state_d = MONITOR;
    if (state_q == MONITOR) begin
      cyc_d = cyc_q == CW'(MAX_CYCLES) ? cyc_q : cyc_q + CW'(1);
      if (fetch_valid) begin
        hist_d[1] = pc;
        for (int k = 2; k <= MAX_PERIOD; k++) hist_d[k] = hist_q[k-1];
        run_d = run_n;
        vdepth_d = vdepth_q == PW'(MAX_PERIOD) ? vdepth_q : vdepth_q + PW'(1);
        fcnt_d = fcnt_q == '1 ? fcnt_q : fcnt_q + 32'd1;
      end
      if (fetch_valid && hit) begin
        state_d = LOOP;
        det_d = 1'b1;
        per_d = hit_p;
        lpc_d = pc;
      end else if (MAX_CYCLES != 0 && cyc_q == CW'(MAX_CYCLES)) begin
        state_d = TIMEOUT;
        to_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      state_q <= IDLE;
      for (int k = 1; k <= MAX_PERIOD; k++) begin
        hist_q[k] <= '0;
        run_q[k] <= '0;
      end
      vdepth_q <= '0;
      cyc_q <= '0;
      fcnt_q <= '0;
      det_q <= 1'b0;
      per_q <= '0;
      lpc_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      run_q <= run_d;
      vdepth_q <= vdepth_d;
      cyc_q <= cyc_d;
      fcnt_q <= fcnt_d;
      det_q <= det_d;
      per_q <= per_d;
      lpc_q <= lpc_d;
      to_q <= to_d;
    end
  end
  assign loop_detected = det_q;
  assign loop_period = per_q;
  assign loop_pc = lpc_q;
  assign timeout = to_q;
  assign halt_req = det_q | to_q;
  assign fetch_count = fcnt_q;
endmodule
